// File: rtl/seq_lut_multiplier.sv
// Sequential unsigned multiplier: retires two bits of B per clock through a {0,A,2A,3A} partial-product table.
// Latency: WIDTH_B/2 cycles from the start-sampling edge to done (SEQ_MULT_EARLY_TERM_EN stops after the top nonzero digit).
// Backpressure: none; start is only sampled in IDLE, and requests arriving while busy are dropped, not queued.
//
// Build option: define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining digits of B are all zero.
// Products are identical either way; only the done timing changes.

module seq_lut_multiplier #(
    parameter int WIDTH_A = 8,   // multiplicand width, >= 1
    parameter int WIDTH_B = 8    // multiplier width, even and >= 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WIDTH_A-1:0]         A,
    input  logic [WIDTH_B-1:0]         B,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH_A+WIDTH_B-1:0] M
);

    // Number of 2-bit digits in B, and the counter width needed to index them.
    localparam int N     = WIDTH_B / 2;
    localparam int WM    = WIDTH_A + WIDTH_B;
    localparam int WPP   = WIDTH_A + 2;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    // Control states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH_A-1:0] a_r;
    logic [WIDTH_B-1:0] b_sh;
    logic [WM-1:0]      acc;
    logic [CNT_W-1:0]   cnt;

    logic [WPP-1:0]     a_ext;
    logic [WPP-1:0]     pp;
    logic [WM-1:0]      pp_sh;
    logic [WM-1:0]      acc_nxt;
    logic [WIDTH_B-1:0] b_sh_nxt;
    logic               last_digit;
    logic               finish;

    // Status is a pure decode of the state register, so it changes only on clock edges.
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Multiplicand widened by two bits so that 3*A cannot overflow the partial product.
    assign a_ext = {2'b00, a_r};

    // Partial-product table indexed by the current (least significant remaining) digit of B.
    always_comb begin
        pp = '0;
        case (b_sh[1:0])
            2'b00:   pp = '0;
            2'b01:   pp = a_ext;
            2'b10:   pp = a_ext << 1;
            2'b11:   pp = (a_ext << 1) + a_ext;
            default: pp = '0;
        endcase
    end

    // Weight the partial product by its digit position (2 bits per digit) and add it in.
    // The full product fits in WM bits, so the sum never carries out.
    assign pp_sh    = WM'(pp) << {cnt, 1'b0};
    assign acc_nxt  = acc + pp_sh;
    assign b_sh_nxt = b_sh >> 2;

    assign last_digit = (cnt == LAST_CNT);

`ifdef SEQ_MULT_EARLY_TERM_EN
    // Once every digit above the current one is zero, the remaining steps would add nothing.
    assign finish = last_digit || (b_sh_nxt == '0);
`else
    // Fixed schedule: always walk all N digits.
    assign finish = last_digit;
`endif

    // Control FSM plus datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            a_r   <= '0;
            b_sh  <= '0;
            acc   <= '0;
            cnt   <= '0;
            M     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r   <= A;
                        b_sh  <= B;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc  <= acc_nxt;
                    b_sh <= b_sh_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    if (finish) begin
                        // M is the only externally visible result and moves only here.
                        M     <= acc_nxt;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_lut_multiplier.sv
module tb_seq_lut_multiplier;

    logic        clk;
    logic        reset;

    // Default-width instance (8x8).
    logic        start8;
    logic [7:0]  A8;
    logic [7:0]  B8;
    logic        busy8;
    logic        done8;
    logic [15:0] M8;

    // Narrow instance (5x6, three digits).
    logic        start5;
    logic [4:0]  A5;
    logic [5:0]  B5;
    logic        busy5;
    logic        done5;
    logic [10:0] M5;

    int total;
    int bad;

    seq_lut_multiplier #(.WIDTH_A(8), .WIDTH_B(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .A     (A8),
        .B     (B8),
        .busy  (busy8),
        .done  (done8),
        .M     (M8)
    );

    seq_lut_multiplier #(.WIDTH_A(5), .WIDTH_B(6)) dut2 (
        .clk   (clk),
        .reset (reset),
        .start (start5),
        .A     (A5),
        .B     (B5),
        .busy  (busy5),
        .done  (done5),
        .M     (M5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sel;   // 0: 8x8 instance, 1: 5x6 instance
        int unsigned a;
        int unsigned b;
        int unsigned m;
        int          lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected latency from the digit pattern of B.
    function automatic int exp_lat(input int unsigned b, input int nd);
        int hi;
        hi = 0;
        for (int i = 0; i < nd; i++)
            if (((b >> (2 * i)) & 3) != 0) hi = i + 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
        return (hi == 0) ? 1 : hi;
`else
        return nd;
`endif
    endfunction

    function automatic bit get_busy(input bit sel);
        return sel ? busy5 : busy8;
    endfunction

    function automatic bit get_done(input bit sel);
        return sel ? done5 : done8;
    endfunction

    function automatic int unsigned get_m(input bit sel);
        return sel ? int'(M5) : int'(M8);
    endfunction

    // Called at a negedge: pulses start for one edge, scrambles the operand
    // inputs afterwards, then observes the busy/done pattern until idle again.
    task automatic run_op(input bit sel, input int unsigned a, input int unsigned b,
                          output int unsigned m, output int lat,
                          output int busy_n, output int done_n);
        m = 0; lat = -1; busy_n = 0; done_n = 0;
        if (sel) begin A5 = a[4:0]; B5 = b[5:0]; start5 = 1'b1; end
        else     begin A8 = a[7:0]; B8 = b[7:0]; start8 = 1'b1; end
        @(negedge clk);
        start5 = 1'b0; start8 = 1'b0;
        A5 = 5'($urandom); B5 = 6'($urandom);
        A8 = 8'($urandom); B8 = 8'($urandom);
        for (int c = 0; c < 40; c++) begin
            if (!get_busy(sel)) break;
            busy_n++;
            if (get_done(sel)) begin
                done_n++;
                if (done_n == 1) begin
                    lat = c;
                    m   = get_m(sel);
                end
            end
            @(negedge clk);
        end
    endtask

    int unsigned m;
    int          lat;
    int          busy_n;
    int          done_n;
    int          cnt;
    int unsigned ra;
    int unsigned rb;

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        start8 = 1'b0; A8 = '0; B8 = '0;
        start5 = 1'b0; A5 = '0; B5 = '0;

        vecs[0] = '{sel: 1'b0, a: 200, b: 150, m: 30000, lat: 4};
        vecs[1] = '{sel: 1'b0, a: 255, b: 255, m: 65025, lat: 4};
        vecs[2] = '{sel: 1'b0, a: 0,   b: 173, m: 0,     lat: 4};
`ifdef SEQ_MULT_EARLY_TERM_EN
        vecs[3] = '{sel: 1'b0, a: 77,  b: 3,   m: 231,   lat: 1};
`else
        vecs[3] = '{sel: 1'b0, a: 77,  b: 3,   m: 231,   lat: 4};
`endif
        vecs[4] = '{sel: 1'b1, a: 31,  b: 63,  m: 1953,  lat: 3};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_busy8", busy8, 0);
        check("reset_done8", done8, 0);
        check("reset_m8",    M8,    0);
        check("reset_busy5", busy5, 0);
        check("reset_m5",    M5,    0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table.
        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, m, lat, busy_n, done_n);
            check($sformatf("vec%0d_m", i),      m,      vecs[i].m);
            check($sformatf("vec%0d_lat", i),    lat,    vecs[i].lat);
            check($sformatf("vec%0d_busy", i),   busy_n, vecs[i].lat + 1);
            check($sformatf("vec%0d_done", i),   done_n, 1);
            check($sformatf("vec%0d_hold", i),   get_m(vecs[i].sel), vecs[i].m);
        end

        // start held high through RUN/DONE with different operands: ignored until after DONE.
        A8 = 8'd200; B8 = 8'd150; start8 = 1'b1;
        @(negedge clk);
        A8 = 8'd3; B8 = 8'd5;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            if (done8) begin lat = c; break; end
            @(negedge clk);
        end
        check("held_lat", lat, 4);
        check("held_m",   M8,  30000);
        @(negedge clk);
        check("held_idle_after_done", busy8, 0);
        @(negedge clk);
        check("held_accept_next", busy8, 1);
        start8 = 1'b0;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            if (done8) begin lat = c; break; end
            @(negedge clk);
        end
        check("held_second_lat", lat, exp_lat(5, 4));
        check("held_second_m",   M8,  15);
        for (int c = 0; c < 5 && busy8; c++) @(negedge clk);

        // Reset two cycles into an operation.
        A8 = 8'd9; B8 = 8'd9; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_m",    M8,    0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (done8 || busy8) cnt++;
            @(negedge clk);
        end
        check("abort_no_done", cnt, 0);
        run_op(1'b0, 9, 9, m, lat, busy_n, done_n);
        check("after_abort_m",   m,   81);
        check("after_abort_lat", lat, exp_lat(9, 4));

        // Randomised operations on the narrow instance.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom_range(0, 31);
            rb = $urandom_range(0, 63);
            run_op(1'b1, ra, rb, m, lat, busy_n, done_n);
            check($sformatf("rnd5_m a=%0d b=%0d", ra, rb),   m,   ra * rb);
            check($sformatf("rnd5_lat a=%0d b=%0d", ra, rb), lat, exp_lat(rb, 3));
        end

        // Randomised operations on the default instance, biased towards sparse B.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom_range(0, 255);
            rb = (i % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            run_op(1'b0, ra, rb, m, lat, busy_n, done_n);
            check($sformatf("rnd8_m a=%0d b=%0d", ra, rb),   m,   ra * rb);
            check($sformatf("rnd8_lat a=%0d b=%0d", ra, rb), lat, exp_lat(rb, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
